// File: rtl/rand_byte_uart_tx.sv
// Random-byte UART transmitter: buffers TRNG bytes in a small FIFO
// and serializes them 8N1, flagging bytes lost to a full buffer.
module rand_byte_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          byte_ready,
  input  logic [7:0]                    rand_byte,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            busy_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic            pop;
  logic            push;
  logic            drop;
  logic            baud_last;

  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);
  assign push      = byte_ready && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
  assign drop      = byte_ready && !push;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  // FIFO pointer, occupancy and sticky-overflow next state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= rand_byte;
  end

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_q];
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rand_byte_uart_tx.sv
// Bench for rand_byte_uart_tx: frame-timing reference model driven
// by randomized and directed byte streams.
module tb_rand_byte_uart_tx;

  localparam int C = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] rand_byte = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  rand_byte_uart_tx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_ready(byte_ready),
    .rand_byte (rand_byte),
    .clr_ovf   (clr_ovf),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // reference model: pending bytes, current frame start edge, flag
  logic [7:0] mq [$];
  logic [7:0] m_cur = 8'h00;
  logic       m_active = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_s = 0;
  int         ecnt = 0;

  function automatic logic exp_busy();
    return m_active && ((ecnt - m_s) < 10 * C);
  endfunction

  function automatic logic exp_tx();
    int o;
    if (!exp_busy()) return 1'b1;
    o = ecnt - m_s;
    if (o < C) return 1'b0;
    if (o < 9 * C) return m_cur[o / C - 1];
    return 1'b1;
  endfunction

  function automatic logic [5:0] exp_vec();
    return {exp_tx(), exp_busy(), 3'(mq.size()), m_ovf};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {tx, busy, fifo_count, overflow};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // one clock: drive inputs, advance DUT and model, settle past edge
  task automatic step(input logic br, input logic [7:0] b,
                      input logic clr);
    logic idle, pop, push, drop;
    byte_ready = br;
    rand_byte  = b;
    clr_ovf    = clr;
    @(posedge clk);
    ecnt++;
    if (rst_n) begin
      idle = !m_active || (ecnt > m_s + 10 * C);
      pop  = idle && (mq.size() > 0);
      push = br && ((mq.size() < D) || pop);
      drop = br && !push;
      if (pop) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_s      = ecnt;
      end
      if (push) mq.push_back(b);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
    byte_ready = 1'b0;
    clr_ovf    = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      step(i[0], 8'($urandom), 1'b0);
      checks++;
      if (obs_vec() !== 6'b100000) begin
        errors++;
        $display("FAIL reset {tx,busy,cnt,ovf} got %b exp %b",
                 obs_vec(), 6'b100000);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle got %b exp %b", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int t0;
    step(1'b1, 8'hA5, 1'b0);
    t0 = ecnt;
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 8'h00, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single t=%0d got %b exp %b",
                 ecnt - t0, obs_vec(), exp_vec());
      end
      if (ecnt == t0 + 41) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL single_end busy got %b exp 0", busy);
        end
      end
    end
  endtask

  task automatic test_burst();
    int peak = 0;
    int n = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL burst_push got %b exp %b", obs_vec(), exp_vec());
      end
    end
    while ((exp_busy() || mq.size() > 0) && n < 400) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL burst t=%0d got %b exp %b", n, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (peak != 4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_peak peak %0d ovf %b exp 4 0", peak, overflow);
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 8'hED)), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set ovf %b cnt %0d exp 1 4", overflow, fifo_count);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %b exp 0", overflow);
    end
    while ((exp_busy() || mq.size() > 0) && n < 400) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_drain t=%0d got %b exp %b",
                 n, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_pushpop();
    int n = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    while (!(ecnt + 1 > m_s + 10 * C) && n < 100) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    checks++;
    if (n >= 100 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_pre cnt %0d waited %0d exp 4", fifo_count, n);
    end
    step(1'b1, 8'h3C, 1'b0);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop cnt %0d ovf %b busy %b exp 4 0 1",
               fifo_count, overflow, busy);
    end
    n = 0;
    while ((exp_busy() || mq.size() > 0) && n < 400) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain t=%0d got %b exp %b",
                 n, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < ((i / 200) % 2 ? 30 : 3)),
           8'($urandom), ($urandom_range(0, 49) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random t=%0d got %b exp %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while ((exp_busy() || mq.size() > 0) && n < 400) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    n = 0;
    while (!(m_active && (ecnt - m_s) == 4 * C + 1) && n < 100) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (n >= 100 || obs_vec() !== 6'b100000) begin
      errors++;
      $display("FAIL reset_mid got %b exp %b waited %0d",
               obs_vec(), 6'b100000, n);
    end
    step(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 8'h00, 1'b0);
      checks++;
      if (tx !== 1'b1 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_after t=%0d got %b exp %b",
                 i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pushpop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
